branch_predictor: RTL and testbench

//  Fetch-side branch predictor: the front end of the branch path whose back end is the

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_predictor_sat_counter2.sv | 24 ++
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch-path types: BHT counter states, predictor FSM states and the
// branch funct3 encodings also decoded by the execute-stage comparator.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } bp_state_t;

  localparam logic [2:0] BR_FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] BR_FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] BR_FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] BR_FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] BR_FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] BR_FUNCT3_BGEU = 3'b111;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Purpose: 2-bit saturating direction counter next-state function.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module sat_counter2
  import branch_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next
);

  bht_ctr_t cur;

  always_comb begin
    cur  = bht_ctr_t'(ctr);
    next = ctr;
    if (taken) begin
      if (cur != ST) next = ctr + 2'd1;
    end else begin
      if (cur != SNT) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Purpose: fetch-side BHT+BTB direction/target predictor trained by execute results.
// Latency: 1 cycle lookup->prediction, 1 cycle update->mispredict pulse.
// Backpressure: none; ready low during table init, requests then are dropped.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  bp_state_t        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q;
  logic             is_ready;

  logic [1:0]       ctr_q    [ENTRIES];
  logic             btb_v_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, lk_taken, lk_fire;
  logic [1:0]       ctr_next;
  logic             unused_pc_lsbs;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_idx_q == IDX_W'(ENTRIES - 1)) state_d = READY;
  end

  always_comb begin
    is_ready = (state_q == READY);
  end

  assign ready = is_ready;

  always_ff @(posedge clk) begin
    if (rst)                   init_idx_q <= '0;
    else if (state_q == INIT)  init_idx_q <= init_idx_q + 1'b1;
  end

  sat_counter2 u_ctr_upd (
    .ctr   (ctr_q[up_idx]),
    .taken (upd_taken),
    .next  (ctr_next)
  );

  // Tables carry no reset; the INIT sweep establishes every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        ctr_q[init_idx_q]   <= WNT;
        btb_v_q[init_idx_q] <= 1'b0;
      end else if (upd_valid) begin
        ctr_q[up_idx] <= ctr_next;
        if (upd_taken) begin
          btb_v_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= upd_target;
        end
      end
    end
  end

  // Read is combinational from the pre-edge tables, so a same-cycle update
  // to the looked-up index is not visible until the next lookup.
  assign lk_hit   = btb_v_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][1];
  assign lk_fire  = is_ready && lookup_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      mispredict  <= 1'b0;
    end else begin
      pred_valid  <= lk_fire;
      pred_taken  <= lk_fire && lk_taken;
      pred_target <= (lk_fire && lk_taken) ? target_q[lk_idx] : '0;
      mispredict  <= is_ready && upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_pred_target != upd_target)));
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int PC_W    = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ready;
  logic            lookup_valid = 1'b0;
  logic [PC_W-1:0] lookup_pc = '0;
  logic            pred_valid, pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic [PC_W-1:0] upd_target = '0;
  logic            upd_pred_taken = 1'b0;
  logic [PC_W-1:0] upd_pred_target = '0;
  logic            mispredict;

  branch_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic        taken;
    logic [31:0] target;
  } pexp_t;

  pexp_t pq[$];
  int    mq[$];

  // Reference model: one record per table slot, plain integers for counters.
  int          m_ctr [ENTRIES];
  bit          m_v   [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_init();
    for (int i = 0; i < ENTRIES; i++) begin
      m_ctr[i] = 1;
      m_v[i]   = 1'b0;
    end
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i  = m_idx(pc);
    tk = m_v[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    tg = tk ? m_tgt[i] : 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pred_valid || (pq.size() > 0 && pq[0].cyc <= cyc)) begin
        if (pq.size() == 0) begin
          chk("spurious_pred_valid", {31'h0, pred_valid}, 32'h0);
        end else begin
          pexp_t e;
          e = pq.pop_front();
          chk("pred_cycle", cyc, e.cyc);
          chk("pred_valid", {31'h0, pred_valid}, 32'h1);
          chk("pred_taken", {31'h0, pred_taken}, {31'h0, e.taken});
          chk("pred_target", pred_target, e.target);
        end
      end else begin
        chk("idle_pred_taken", {31'h0, pred_taken}, 32'h0);
        chk("idle_pred_target", pred_target, 32'h0);
      end
      if (mispredict || (mq.size() > 0 && mq[0] <= cyc)) begin
        if (mq.size() == 0) chk("spurious_mispredict", {31'h0, mispredict}, 32'h0);
        else begin
          chk("mispredict_cycle", cyc, mq.pop_front());
          chk("mispredict_value", {31'h0, mispredict}, 32'h1);
        end
      end
    end
  end

  task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit upt, input logic [31:0] uptgt);
    pexp_t e;
    int i;
    @(posedge clk);
    #1;
    lookup_valid = lv;  lookup_pc = lpc;
    upd_valid = uv;     upd_pc = upc;       upd_taken = ut;
    upd_target = utgt;  upd_pred_taken = upt; upd_pred_target = uptgt;
    if (lv) begin
      e.cyc = cyc + 1;
      model_pred(lpc, e.taken, e.target);
      pq.push_back(e);
    end
    if (uv) begin
      if ((ut != upt) || (ut && (utgt != uptgt))) mq.push_back(cyc + 1);
      i = m_idx(upc);
      if (ut) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_v[i]   = 1'b1;
        m_tag[i] = m_tagof(upc);
        m_tgt[i] = utgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Requests stay asserted throughout INIT; any that leak through surface as
  // unexpected predictions or mispredict pulses in the monitor.
  task automatic reset_and_wait(input int abort_at);
    int n;
    bit got;
    @(posedge clk);
    #1;
    rst = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h80; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(negedge clk);
      chk("ready_low_before_abort", {31'h0, ready}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end
    model_init();
    @(negedge clk);
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_pred_valid", {31'h0, pred_valid}, 32'h0);
    chk("reset_mispredict", {31'h0, mispredict}, 32'h0);
    got = ready;
    n = ready ? 0 : 1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (ready) got = 1'b1;
      else n++;
    end
    lookup_valid = 1'b0;
    upd_valid = 1'b0;
    chk("init_reached_ready", {31'h0, got}, 32'h1);
    chk("init_low_cycles", n, ENTRIES);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        pt;
    logic [31:0] ptg, lpc, upc, utgt;
    bit          ut;

    reset_and_wait(0);

    // Cold lookup, then taken update that trains WNT->WT and allocates the BTB.
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    idle();
    drive(0, 0, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    // Walk the counter down to SNT and confirm it saturates there.
    drive(0, 0, 1, 32'h100, 0, 32'h0, 1, 32'h80);
    drive(0, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    // Retrain taken, then probe an aliasing PC with a different tag.
    drive(0, 0, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    drive(0, 0, 1, 32'h100, 1, 32'h80, 0, 32'h0);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h100 + 4 * ENTRIES, 0, 0, 0, 0, 0, 0);
    // Same-cycle lookup and update: lookup sees pre-update contents.
    drive(1, 32'h200, 1, 32'h200, 1, 32'h300, 1, 32'h304);
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0);
    idle();

    for (int k = 0; k < 400; k++) begin
      lpc  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
      upc  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
      ut   = $urandom_range(0, 99) < 60;
      utgt = 32'h1000 + ($urandom_range(0, 3) << 4);
      model_pred(upc, pt, ptg);
      if ($urandom_range(0, 3) == 0) pt = ~pt;
      if ($urandom_range(0, 3) == 0) ptg = utgt ^ 32'h10;
      else if (pt) ptg = utgt;
      drive($urandom_range(0, 1), lpc, $urandom_range(0, 1), upc, ut, utgt, pt, ptg);
    end

    // Mid-INIT reset restarts the sweep; tables come back cold.
    reset_and_wait(20);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    @(negedge clk);
    chk("pred_queue_drained", pq.size(), 0);
    chk("mispredict_queue_drained", mq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
